// File: rtl/fpu_shift_pkg.sv
// Shared types and size helpers for the pipelined FPU barrel shifter.
package fpu_shift_pkg;

  typedef enum logic [1:0] {
    SH_LRL  = 2'b00,
    SH_ARL  = 2'b01,
    SH_FILL = 2'b10,
    SH_LL   = 2'b11
  } shift_mode_e;

  function automatic int levels_f(input int width);
    return $clog2(width);
  endfunction

  function automatic int stages_f(input int width, input int lps);
    return (levels_f(width) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/fpu_shift_level.sv
// One 2^K right-shift level: vacated bits take fill, dropped bits feed sticky.
// Sticky OR is only built when FPU_SHIFT_STICKY_EN is defined.
module fpu_shift_level #(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             fill,
  input  logic             sticky_in,
  output logic [WIDTH-1:0] data_out,
  output logic             sticky_out
);
  localparam int S = 1 << K;

  assign data_out = enable ? {{S{fill}}, data_in[WIDTH-1:S]} : data_in;

`ifdef FPU_SHIFT_STICKY_EN
  assign sticky_out = sticky_in | (enable & (|data_in[S-1:0]));
`else
  assign sticky_out = sticky_in;
`endif

endmodule

// File: rtl/fpu_pipe_shifter.sv
// Elastic pipelined barrel shifter (logical/arith/fill right, logical left).
// Define FPU_SHIFT_STICKY_EN to compute o_sticky; otherwise it is tied to 0.
module fpu_pipe_shifter
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int AMT_W            = 8,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic [1:0]       i_mode,
  input  logic             i_new_bit,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sticky,
  output logic [TAG_W-1:0] o_tag
);
  localparam int LEVELS = levels_f(WIDTH);
  localparam int STAGES = stages_f(WIDTH, LEVELS_PER_STAGE);
  localparam int LPS    = LEVELS_PER_STAGE;
  localparam logic [AMT_W:0] WIDTH_C = (AMT_W+1)'(WIDTH);

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  data;
    logic [LEVELS-1:0] amt;
    shift_mode_e       mode;
    logic              fill;
    logic              sticky;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  stage_t            acc;
  stage_t            last;
  logic              sat;
  logic [WIDTH-1:0]  data_rev;
  logic [WIDTH-1:0]  last_rev;
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;
  logic              unused_last;

  // Left shifts run as right shifts on the bit-reversed operand.
  assign data_rev = {<<{i_data}};
  assign sat      = {1'b0, i_amt} >= WIDTH_C;

  always_comb begin
    acc       = '0;
    acc.valid = i_valid;
    acc.mode  = shift_mode_e'(i_mode);
    acc.tag   = i_tag;
    case (acc.mode)
      SH_ARL:  acc.fill = i_data[WIDTH-1];
      SH_FILL: acc.fill = i_new_bit;
      default: acc.fill = 1'b0;
    endcase
    if (sat) begin
      // Saturated beats flow through with zero amount so latency is unchanged.
      acc.data = {WIDTH{acc.fill}};
      acc.amt  = '0;
`ifdef FPU_SHIFT_STICKY_EN
      acc.sticky = |i_data;
`endif
    end else begin
      acc.data = (acc.mode == SH_LL) ? data_rev : i_data;
      acc.amt  = i_amt[LEVELS-1:0];
    end
  end

  always_comb begin
    rdy[STAGES] = i_ready;
    for (int s = STAGES-1; s >= 0; s--)
      rdy[s] = !vld[s] | rdy[s+1];
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t src;
    stage_t nxt;
    stage_t q;

    if (s == 0) begin : g_src0
      assign src = acc;
    end else begin : g_srcn
      assign src = g_stage[s-1].q;
    end

    for (genvar j = 0; j < LPS; j++) begin : g_lvl
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] dout;
      logic             sin;
      logic             sout;

      if (j == 0) begin : g_first
        assign din = src.data;
        assign sin = src.sticky;
      end else begin : g_next
        assign din = g_lvl[j-1].dout;
        assign sin = g_lvl[j-1].sout;
      end

      if (s*LPS + j < LEVELS) begin : g_on
        fpu_shift_level #(.WIDTH(WIDTH), .K(s*LPS + j)) u_lvl (
          .data_in   (din),
          .enable    (src.amt[s*LPS + j]),
          .fill      (src.fill),
          .sticky_in (sin),
          .data_out  (dout),
          .sticky_out(sout)
        );
      end else begin : g_off
        assign dout = din;
        assign sout = sin;
      end
    end

    always_comb begin
      nxt        = src;
      nxt.data   = g_lvl[LPS-1].dout;
      nxt.sticky = g_lvl[LPS-1].sout;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    q <= '0;
      else if (rdy[s]) q <= nxt;
    end

    assign vld[s] = q.valid;
  end

  assign last     = g_stage[STAGES-1].q;
  assign last_rev = {<<{last.data}};

  assign o_ready = rdy[0];
  assign o_valid = last.valid;
  assign o_tag   = last.tag;
  assign o_data  = (last.mode == SH_LL) ? last_rev : last.data;
`ifdef FPU_SHIFT_STICKY_EN
  assign o_sticky = last.sticky;
`else
  assign o_sticky = 1'b0;
`endif

  assign unused_last = ^{last.amt, last.fill, last.sticky};

endmodule

// File: tb/tb_fpu_pipe_shifter.sv
// Directed bench for fpu_pipe_shifter: arithmetic reference model + scoreboard,
// with literal vectors pinning the model (sticky expectations honour FPU_SHIFT_STICKY_EN).
module tb_fpu_pipe_shifter;
  localparam int WIDTH = 32;
  localparam int AMT_W = 8;
  localparam int LPS   = 2;
  localparam int TAG_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] i_data = '0;
  logic [AMT_W-1:0] i_amt = '0;
  logic [1:0]       i_mode = '0;
  logic             i_new_bit = 1'b0;
  logic [TAG_W-1:0] i_tag = '0;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [WIDTH-1:0] o_data;
  logic             o_sticky;
  logic [TAG_W-1:0] o_tag;

  fpu_pipe_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W), .LEVELS_PER_STAGE(LPS), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_amt(i_amt), .i_mode(i_mode), .i_new_bit(i_new_bit),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_sticky(o_sticky), .o_tag(o_tag)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic [3:0]  t;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        stalled = 1'b0;
  logic [31:0] hold_d;
  logic        hold_s;
  logic [3:0]  hold_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: widen to 64 bits and shift with plain operators.
  function automatic void model(input logic [31:0] d, input logic [7:0] a, input logic [1:0] m,
                                input logic nb, output logic [31:0] r, output logic s);
    logic        f;
    logic [63:0] w;
    f = (m == 2'b01) ? d[31] : (m == 2'b10) ? nb : 1'b0;
    if (a >= 8'd32) begin
      r = {32{f}};
      s = |d;
    end else if (m == 2'b11) begin
      w = {32'b0, d} << a;
      r = w[31:0];
      s = |w[63:32];
    end else begin
      w = {{32{f}}, d} >> a;
      r = w[31:0];
      w = {32'b0, d} & ((64'd1 << a) - 64'd1);
      s = |w;
    end
`ifndef FPU_SHIFT_STICKY_EN
    s = 1'b0;
`endif
  endfunction

  // Scoreboard: push on accept, pop on handshake, hold check while stalled.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst_n) begin
      sb.delete();
      stalled = 1'b0;
      chk("rst_valid", o_valid, 0);
    end else begin
      if (stalled) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, hold_d);
        chk("hold_sticky", o_sticky, hold_s);
        chk("hold_tag", o_tag, hold_t);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_valid: got o_valid=1 with no beat outstanding");
        end else begin
          e = sb.pop_front();
          chk("sb_data", o_data, e.d);
          chk("sb_sticky", o_sticky, e.s);
          chk("sb_tag", o_tag, e.t);
        end
      end
      stalled = o_valid && !i_ready;
      hold_d = o_data;
      hold_s = o_sticky;
      hold_t = o_tag;
      if (i_valid && o_ready) begin
        model(i_data, i_amt, i_mode, i_new_bit, e.d, e.s);
        e.t = i_tag;
        sb.push_back(e);
      end
    end
  end

  // One beat with free-flowing output; checks accept, latency and literal result.
  task automatic single(input string nm, input logic [31:0] d, input logic [7:0] a,
                        input logic [1:0] m, input logic nb, input logic [3:0] t,
                        input logic [31:0] ed, input logic es);
    int   n;
    logic ok;
`ifndef FPU_SHIFT_STICKY_EN
    es = 1'b0;
`endif
    i_data = d; i_amt = a; i_mode = m; i_new_bit = nb; i_tag = t;
    i_valid = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    ok = o_ready;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk({nm, "_accept"}, ok, 1);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < 10);
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_data"}, o_data, ed);
    chk({nm, "_sticky"}, o_sticky, es);
    chk({nm, "_tag"}, o_tag, t);
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [3:0] pat;
    int         k;
    int         guard;
    logic       acc;

    pat = 4'b1001;
    @(negedge i_clk);
    chk("reset_valid", o_valid, 0);
    chk("reset_data", o_data, 0);
    chk("reset_sticky", o_sticky, 0);
    chk("reset_tag", o_tag, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("ready_after_reset", o_ready, 1);
    @(posedge i_clk); #1;

    single("lrl4",  32'hF000_000F, 8'd4,  2'b00, 1'b0, 4'd1, 32'h0F00_0000, 1'b1);
    single("arl5",  32'h8000_0010, 8'd5,  2'b01, 1'b0, 4'd2, 32'hFC00_0000, 1'b1);
    single("arl4",  32'h8000_0010, 8'd4,  2'b01, 1'b0, 4'd3, 32'hF800_0001, 1'b0);
    single("sat40", 32'h0000_00FF, 8'd40, 2'b10, 1'b1, 4'd4, 32'hFFFF_FFFF, 1'b1);
    single("ll31",  32'h0000_0001, 8'd31, 2'b11, 1'b0, 4'd5, 32'h8000_0000, 1'b0);
    single("amt0",  32'hDEAD_BEEF, 8'd0,  2'b01, 1'b0, 4'd6, 32'hDEAD_BEEF, 1'b0);
    single("lrl16", 32'hFFFF_FFFF, 8'd16, 2'b00, 1'b0, 4'd7, 32'h0000_FFFF, 1'b1);

    // Back-to-back stream under a 1,0,0,1 ready pattern.
    k = 0;
    for (int b = 0; b < 10; b++) begin
      i_data  = 32'h9A5C_3E71 ^ (32'h0101_0101 * b);
      i_amt   = (b == 7) ? 8'd200 : 8'(b * 3);
      i_mode  = 2'(b % 4);
      i_new_bit = b[0];
      i_tag   = 4'(b);
      i_valid = 1'b1;
      guard = 0;
      do begin
        i_ready = pat[k % 4];
        k++;
        @(negedge i_clk);
        acc = o_ready;
        @(posedge i_clk); #1;
        guard++;
      end while (!acc && guard < 20);
      if (!acc) chk("stream_accept_timeout", 0, 1);
    end
    i_valid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      i_ready = pat[k % 4];
      k++;
      @(posedge i_clk); #1;
      guard++;
    end
    i_ready = 1'b1;
    chk("stream_drained", sb.size(), 0);

    // Three beats in flight, then reset for two cycles.
    i_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      i_data = 32'h1111_1111 * (b + 1); i_amt = 8'd1; i_mode = 2'b00; i_tag = 4'(b + 10);
      i_valid = 1'b1;
      @(negedge i_clk);
      chk("flight_accept", o_ready, 1);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      chk("midrst_valid", o_valid, 0);
      chk("midrst_ready", o_ready, 1);
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("post_rst_valid", o_valid, 0);
    end
    @(posedge i_clk); #1;
    single("post_rst", 32'h1234_5678, 8'd0, 2'b00, 1'b0, 4'd9, 32'h1234_5678, 1'b0);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    chk("final_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
